// File: rtl/ecdsa_pkg.sv
// Shared definitions for the ECDSA scalar-multiplication datapath:
// point-operation command encodings and the default scalar width.
package ecdsa_pkg;
    localparam int N_DEFAULT = 256;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_DBL  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_END  = 3'd4;
endpackage

// File: rtl/scalar_op_sequencer_naf_recoder.sv
// Serial non-adjacent-form recoder: one digit per cycle, N+1 digits,
// delivered as pos/neg bit vectors (digit i is +1, -1 or 0).
module naf_recoder #(
    parameter int N  = 256,
    parameter int IW = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] k,
    output logic         busy,
    output logic         done,
    output logic [N:0]   pos,
    output logic [N:0]   neg
);
    logic [N:0]    k_reg;
    logic [IW-1:0] cnt_reg;
    logic          busy_reg;
    logic          done_reg;
    logic [N:0]    pos_reg;
    logic [N:0]    neg_reg;
    logic          dig_pos;
    logic          dig_neg;

    // k mod 4 == 1 gives +1, k mod 4 == 3 gives -1; after subtracting the
    // digit, k>>1 equals (k>>1)+1 only in the -1 case.
    assign dig_pos = k_reg[0] & ~k_reg[1];
    assign dig_neg = k_reg[0] & k_reg[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            k_reg    <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            pos_reg  <= '0;
            neg_reg  <= '0;
        end else begin
            done_reg <= 1'b0;
            if (!busy_reg && start) begin
                k_reg    <= {1'b0, k};
                cnt_reg  <= '0;
                busy_reg <= 1'b1;
            end else if (busy_reg) begin
                pos_reg <= {dig_pos, pos_reg[N:1]};
                neg_reg <= {dig_neg, neg_reg[N:1]};
                k_reg   <= (k_reg >> 1) + {{N{1'b0}}, dig_neg};
                cnt_reg <= cnt_reg + IW'(1);
                if (cnt_reg == IW'(N)) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign pos  = pos_reg;
    assign neg  = neg_reg;
endmodule

// File: rtl/scalar_op_sequencer.sv
// Left-to-right point-op command generator for kP (LOAD/DBL/ADD/SUB/END).
// Define SCALAR_SEQ_NAF_EN to recode k into NAF first; default uses raw bits.
module scalar_op_sequencer
    import ecdsa_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int IW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [N-1:0]  scalar,
    output logic          busy,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [2:0]    cmd_op,
    output logic [IW-1:0] cmd_idx,
    output logic          zero_scalar,
    output logic          done
);
`ifdef SCALAR_SEQ_NAF_EN
    typedef enum logic [2:0] {S_IDLE, S_RECODE, S_SCAN, S_EMIT_DBL, S_EMIT_ADD, S_EMIT_END} state_e;
`else
    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_EMIT_DBL, S_EMIT_ADD, S_EMIT_END} state_e;
`endif

    state_e        state_reg;
    logic [N:0]    pos_reg;
    logic [N:0]    nz_vec;
    logic          sub_sel;
    logic [IW-1:0] scan_idx_reg;
    logic [IW-1:0] scan_prev;
    logic          busy_reg;
    logic          cmd_valid_reg;
    logic [2:0]    cmd_op_reg;
    logic [IW-1:0] cmd_idx_reg;
    logic          zero_scalar_reg;
    logic          done_reg;
    logic [2:0]    adv_op;
    logic [IW-1:0] adv_idx;
    state_e        adv_state;

`ifdef SCALAR_SEQ_NAF_EN
    logic [N:0] neg_reg;
    logic [N:0] rec_pos;
    logic [N:0] rec_neg;
    logic       rec_busy;
    logic       rec_done;

    naf_recoder #(.N(N), .IW(IW)) u_recoder (
        .clk   (clk),
        .reset (reset),
        .start (state_reg == S_IDLE && start && !done_reg),
        .k     (scalar),
        .busy  (rec_busy),
        .done  (rec_done),
        .pos   (rec_pos),
        .neg   (rec_neg)
    );

    assign nz_vec  = pos_reg | neg_reg;
    assign sub_sel = neg_reg[cmd_idx_reg];
`else
    assign nz_vec  = pos_reg;
    assign sub_sel = 1'b0;
`endif

    // SCAN looks one digit below scan_idx so LOAD(m) is registered in the
    // cycle that would otherwise have examined digit m.
    assign scan_prev = scan_idx_reg - IW'(1);

    always_comb begin
        adv_op    = OP_DBL;
        adv_idx   = cmd_idx_reg - IW'(1);
        adv_state = S_EMIT_DBL;
        if (cmd_idx_reg == '0) begin
            adv_op    = OP_END;
            adv_idx   = '0;
            adv_state = S_EMIT_END;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            pos_reg         <= '0;
`ifdef SCALAR_SEQ_NAF_EN
            neg_reg         <= '0;
`endif
            scan_idx_reg    <= '0;
            busy_reg        <= 1'b0;
            cmd_valid_reg   <= 1'b0;
            cmd_op_reg      <= 3'd0;
            cmd_idx_reg     <= '0;
            zero_scalar_reg <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    // done_reg still high means this is the done cycle: ignore start
                    if (start && !done_reg) begin
                        zero_scalar_reg <= 1'b0;
                        busy_reg        <= 1'b1;
`ifdef SCALAR_SEQ_NAF_EN
                        state_reg       <= S_RECODE;
`else
                        pos_reg         <= {1'b0, scalar};
                        scan_idx_reg    <= IW'(N);
                        state_reg       <= S_SCAN;
`endif
                    end
                end
`ifdef SCALAR_SEQ_NAF_EN
                S_RECODE: begin
                    if (rec_done && !rec_busy) begin
                        pos_reg <= rec_pos;
                        neg_reg <= rec_neg;
                        if (rec_pos[N] | rec_neg[N]) begin
                            cmd_valid_reg <= 1'b1;
                            cmd_op_reg    <= OP_LOAD;
                            cmd_idx_reg   <= IW'(N);
                            state_reg     <= S_EMIT_DBL;
                        end else begin
                            scan_idx_reg <= IW'(N);
                            state_reg    <= S_SCAN;
                        end
                    end
                end
`endif
                S_SCAN: begin
                    if (scan_idx_reg == '0) begin
                        zero_scalar_reg <= 1'b1;
                        cmd_valid_reg   <= 1'b1;
                        cmd_op_reg      <= OP_END;
                        cmd_idx_reg     <= '0;
                        state_reg       <= S_EMIT_END;
                    end else if (nz_vec[scan_prev]) begin
                        cmd_valid_reg <= 1'b1;
                        cmd_op_reg    <= OP_LOAD;
                        cmd_idx_reg   <= scan_prev;
                        state_reg     <= S_EMIT_DBL;
                    end else begin
                        scan_idx_reg <= scan_prev;
                    end
                end
                S_EMIT_DBL: begin
                    if (cmd_ready) begin
                        if (cmd_op_reg == OP_DBL && nz_vec[cmd_idx_reg]) begin
                            cmd_op_reg <= sub_sel ? OP_SUB : OP_ADD;
                            state_reg  <= S_EMIT_ADD;
                        end else begin
                            cmd_op_reg  <= adv_op;
                            cmd_idx_reg <= adv_idx;
                            state_reg   <= adv_state;
                        end
                    end
                end
                S_EMIT_ADD: begin
                    if (cmd_ready) begin
                        cmd_op_reg  <= adv_op;
                        cmd_idx_reg <= adv_idx;
                        state_reg   <= adv_state;
                    end
                end
                S_EMIT_END: begin
                    if (cmd_ready) begin
                        cmd_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                        state_reg     <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_reg;
    assign cmd_valid   = cmd_valid_reg;
    assign cmd_op      = cmd_op_reg;
    assign cmd_idx     = cmd_idx_reg;
    assign zero_scalar = zero_scalar_reg;
    assign done        = done_reg;
endmodule

// File: tb/tb_scalar_op_sequencer.sv
// Bench for scalar_op_sequencer: digit-level reference model plus literal
// sequences, random scalars and random/periodic cmd_ready back-pressure.
module tb_scalar_op_sequencer;
    import ecdsa_pkg::*;

    localparam int N  = N_DEFAULT;
    localparam int IW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [N-1:0]  scalar;
    logic          busy;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [IW-1:0] cmd_idx;
    logic          zero_scalar;
    logic          done;

    scalar_op_sequencer #(.N(N), .IW(IW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .scalar      (scalar),
        .busy        (busy),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_idx     (cmd_idx),
        .zero_scalar (zero_scalar),
        .done        (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_op[$];
    int exp_idx[$];
    bit exp_zero;
    int model_lat;
    bit mon_en = 1'b0;
    bit done_due = 1'b0;
    int hs_count = 0;
    bit seen_valid = 1'b0;
    int first_valid_cyc = 0;
    bit prev_stall = 1'b0;
    logic [2:0] prev_op;
    logic [IW-1:0] prev_idx;
    int ready_mode = 0;
    int rdy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int op, input int idx);
        exp_op.push_back(op);
        exp_idx.push_back(idx);
    endtask

    function automatic int lat(input int v);
`ifdef SCALAR_SEQ_NAF_EN
        return -1;
`else
        return v;
`endif
    endfunction

    // Reference: derive the digit string from k, then the command list from the digits.
    task automatic build_model(input logic [N-1:0] k);
        int dig[N+1];
        int m;
        logic [N+1:0] kk;
        kk = {2'b00, k};
        for (int i = 0; i <= N; i++) begin
`ifdef SCALAR_SEQ_NAF_EN
            if (kk % 4 == 1) begin
                dig[i] = 1;
                kk = kk - 1;
            end else if (kk % 4 == 3) begin
                dig[i] = -1;
                kk = kk + 1;
            end else begin
                dig[i] = 0;
            end
            kk = kk / 2;
`else
            dig[i] = (i < N) ? int'(k[i]) : 0;
`endif
        end
        m = -1;
        for (int i = N; i >= 0; i--) begin
            if (dig[i] != 0) begin
                m = i;
                break;
            end
        end
        exp_op.delete();
        exp_idx.delete();
        exp_zero = (m < 0);
        model_lat = lat((m < 0) ? N + 1 : N - m);
        if (m >= 0) begin
            push(OP_LOAD, m);
            for (int i = m - 1; i >= 0; i--) begin
                push(OP_DBL, i);
                if (dig[i] > 0) push(OP_ADD, i);
                if (dig[i] < 0) push(OP_SUB, i);
            end
        end
        push(OP_END, 0);
    endtask

    always @(posedge clk) begin
        #1;
        rdy_cnt++;
        case (ready_mode)
            0: cmd_ready = 1'b1;
            1: cmd_ready = (rdy_cnt % 3 == 0);
            default: cmd_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Single compare process: handshakes against the expected queue, stalls, done.
    always @(negedge clk) begin
        if (mon_en) begin
            check("done_pulse", done, done_due);
            if (done_due) begin
                check("zero_scalar", zero_scalar, exp_zero);
                check("busy_at_done", busy, 0);
            end
            done_due = 1'b0;
            if (prev_stall) begin
                check("stall_valid", cmd_valid, 1);
                check("stall_op", cmd_op, prev_op);
                check("stall_idx", cmd_idx, prev_idx);
            end
            if (cmd_valid && !seen_valid) begin
                seen_valid = 1'b1;
                first_valid_cyc = cyc;
            end
            if (cmd_valid && cmd_ready) begin
                hs_count++;
                if (exp_op.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cmd: got op %0d idx %0d required none", cmd_op, cmd_idx);
                end else begin
                    int eo;
                    int ei;
                    eo = exp_op.pop_front();
                    ei = exp_idx.pop_front();
                    check("cmd_op", cmd_op, eo);
                    check("cmd_idx", cmd_idx, ei);
                    if (eo == OP_END) done_due = 1'b1;
                end
            end
            prev_stall = cmd_valid && !cmd_ready;
            prev_op    = cmd_op;
            prev_idx   = cmd_idx;
        end
    end

    task automatic run_seq(input logic [N-1:0] k, input int mode, input bit literal,
                           input bit busy_start, input int exp_lat);
        int t0;
        bit got;
        if (!literal) begin
            build_model(k);
            exp_lat = model_lat;
        end
        ready_mode = mode;
        seen_valid = 1'b0;
        @(posedge clk);
        #1;
        scalar = k;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        scalar = {8{$urandom()}};
        @(negedge clk);
        t0 = cyc;
        check("busy_after_start", busy, 1);
        got = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (c > 0) @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy_start && c == 5) start = 1'b1;
            if (busy_start && c == 6) start = 1'b0;
        end
        check("done_seen", got, 1);
        check("queue_drained", exp_op.size(), 0);
        if (exp_lat >= 0) check("first_cmd_latency", first_valid_cyc - t0, exp_lat);
        if (got) begin
            start  = 1'b1;
            scalar = 1;
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            check("start_on_done_ignored", busy, 0);
        end
        exp_op.delete();
        exp_idx.delete();
    endtask

    task automatic lit_k11();
        exp_op.delete();
        exp_idx.delete();
        exp_zero = 1'b0;
`ifdef SCALAR_SEQ_NAF_EN
        push(OP_LOAD, 4); push(OP_DBL, 3); push(OP_DBL, 2); push(OP_SUB, 2);
        push(OP_DBL, 1); push(OP_DBL, 0); push(OP_SUB, 0); push(OP_END, 0);
`else
        push(OP_LOAD, 3); push(OP_DBL, 2); push(OP_DBL, 1); push(OP_ADD, 1);
        push(OP_DBL, 0); push(OP_ADD, 0); push(OP_END, 0);
`endif
    endtask

    task automatic lit_k1();
        exp_op.delete();
        exp_idx.delete();
        exp_zero = 1'b0;
        push(OP_LOAD, 0); push(OP_END, 0);
    endtask

    initial begin
        logic [N-1:0] r;
        int hs0;
        int nd;
        reset = 1'b1;
        start = 1'b0;
        scalar = '0;
        cmd_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_op", cmd_op, 0);
        check("rst_cmd_idx", cmd_idx, 0);
        check("rst_zero_scalar", zero_scalar, 0);
        check("rst_done", done, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;

        lit_k11();
        run_seq(11, 0, 1, 0, lat(N - 3));

        exp_op.delete(); exp_idx.delete();
        exp_zero = 1'b1;
        push(OP_END, 0);
        run_seq(0, 0, 1, 0, lat(N + 1));

        lit_k1();
        run_seq(1, 0, 1, 0, lat(N));

        lit_k11();
        run_seq(11, 1, 1, 0, lat(N - 3));

        exp_op.delete(); exp_idx.delete();
        exp_zero = 1'b0;
`ifdef SCALAR_SEQ_NAF_EN
        push(OP_LOAD, 3); push(OP_DBL, 2); push(OP_DBL, 1); push(OP_DBL, 0); push(OP_SUB, 0);
`else
        push(OP_LOAD, 2); push(OP_DBL, 1); push(OP_ADD, 1); push(OP_DBL, 0); push(OP_ADD, 0);
`endif
        push(OP_END, 0);
        run_seq(7, 2, 1, 0, -1);

        r = '0;
        r[N-1] = 1'b1;
        run_seq(r, 0, 0, 1, 0);
        r = '1;
        run_seq(r, 2, 0, 1, 0);

        // Abort after the second handshake, then a clean restart.
        lit_k11();
        ready_mode = 0;
        hs0 = hs_count;
        @(posedge clk);
        #1;
        scalar = 11;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (hs_count >= hs0 + 2) break;
        end
        check("abort_two_handshakes", hs_count - hs0, 2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        mon_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_cmd_valid", cmd_valid, 0);
        check("abort_cmd_op", cmd_op, 0);
        check("abort_cmd_idx", cmd_idx, 0);
        check("abort_zero_scalar", zero_scalar, 0);
        check("abort_done", done, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_op.delete();
        exp_idx.delete();
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || cmd_valid) nd++;
        end
        check("abort_quiet", nd, 0);
        prev_stall = 1'b0;
        done_due = 1'b0;
        mon_en = 1'b1;
        lit_k1();
        run_seq(1, 0, 1, 0, lat(N));

        for (int t = 0; t < 10; t++) begin
            for (int w = 0; w < N / 32; w++) r[w * 32 +: 32] = $urandom();
            if (t % 2 == 1) r = r >> $urandom_range(0, N - 1);
            run_seq(r, $urandom_range(0, 2), 0, 0, 0);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/scalar_op_sequencer.md
# scalar_op_sequencer

Left-to-right command generator for the ECDSA scalar-multiplication datapath. It takes a scalar k and emits, over a valid/ready handshake, the exact sequence of point operations (LOAD, DBL, ADD, SUB, END) that a point-operation engine must execute to compute kP. It is the transmitter side of the point-op command interface: the engine consumes commands and this block produces them. Scalar bit handling is removed from the arithmetic units.

## Interface
- N, 256, scalar width in bits
- IW, $clog2(N+1), width of cmd_idx
- clk  in  1  clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- start  in  1  load scalar and begin; sampled only in IDLE
- scalar  in  N  k, unsigned
- busy  out  1  high from the cycle after start is accepted until done
- cmd_valid  out  1  command present
- cmd_ready  in  1  engine accepts command
- cmd_op  out  3  0 LOAD, 1 DBL, 2 ADD, 3 SUB, 4 END
- cmd_idx  out  IW  digit position the command belongs to (END: 0)
- zero_scalar  out  1  k==0 was detected; valid from END until next start
- done  out  1  one-cycle pulse after END handshake

## Operation
- States: IDLE, RECODE (NAF build only), SCAN, EMIT_DBL, EMIT_ADD, EMIT_END.
- IDLE: start=1 latches scalar into a working register of N+1 bits, clears zero_scalar, sets busy, moves to RECODE (NAF) or SCAN.
- SCAN: examines one digit per cycle from position N down to 0, skipping zeros. At the first nonzero digit m, emit LOAD with cmd_idx=m. If all digits are zero, set zero_scalar and go to EMIT_END.
- After LOAD, for i = m-1 down to 0: emit DBL (idx i). If digit i = +1, emit ADD (idx i); if digit i = -1, emit SUB (idx i).
- After position 0: EMIT_END emits END. When END handshakes, done pulses, busy clears, and the block returns to IDLE.
- Binary mode digits equal scalar bits. Digit N is always 0 in binary mode.
- Each command is one handshake. The next command is presented the cycle after acceptance; there are no bubbles within the emit phase.

## Timing
- Reset values: busy 0, cmd_valid 0, cmd_op 0, cmd_idx 0, zero_scalar 0, done 0. State is IDLE.
- start accepted at cycle t → busy=1 at t+1; SCAN starts at t+1.
- SCAN costs N-m cycles before LOAD is valid (N+1 cycles for k=0).
- While cmd_valid=1 and cmd_ready=0, cmd_op and cmd_idx are held stable, and cmd_valid is never withdrawn.
- A handshake occurs on a cycle with cmd_valid and cmd_ready both high. The following command is valid on the next cycle.
- done=1 on the cycle after the END handshake. busy=0 on that same cycle.
- start is ignored while busy=1, including the done cycle.
- A start in the same cycle as done is not accepted. start is accepted at the earliest one cycle later.
- reset mid-operation aborts the sequence. All outputs take reset values on the next cycle, and no END or done is produced.
- cmd_ready asserted without cmd_valid has no effect.

## Configuration
- SCALAR_SEQ_NAF_EN defined: RECODE converts k to non-adjacent form, producing N+1 digits in {-1,0,+1} stored as pos/neg bit vectors. Recoding produces one digit per cycle, N+1 cycles, before SCAN. -1 digits emit SUB.
- NAF rule: if k is odd, d = 2-(k mod 4) and k -= d; otherwise d = 0. Then k >>= 1.
- SCALAR_SEQ_NAF_EN undefined: no RECODE state and no neg vector. SUB is never emitted. Digits are the raw bits.

## Structure
- Shared package ecdsa_pkg holds:
  - the op encodings OP_LOAD/OP_DBL/OP_ADD/OP_SUB/OP_END (3-bit);
  - the default N.
- Sub-module naf_recoder (NAF build only) has a start/busy/done interface and outputs the pos/neg vectors. The top FSM waits for its done.

## Test plan
- Binary, k=11 (0b1011), cmd_ready=1 → LOAD(3), DBL(2), DBL(1), ADD(1), DBL(0), ADD(0), END; done pulses once; zero_scalar=0.
- k=0 → single END after N+1 scan cycles; zero_scalar=1; done pulses.
- k=1 → LOAD(0), END. k=2^(N-1) → LOAD(N-1), then N-1 DBLs, then END.
- k=11 with cmd_ready toggling 1-of-3 cycles → identical sequence; outputs stable during every stall cycle.
- NAF build, k=7 → LOAD(3), DBL(2), DBL(1), DBL(0), SUB(0), END. NAF build, k=11 → LOAD(4), DBL(3), DBL(2), SUB(2), DBL(1), DBL(0), SUB(0), END.
- Abort and restart:
  - reset asserted after the second handshake of k=11 → outputs at reset values next cycle; no done.
  - a subsequent start with k=1 → clean LOAD(0), END.
  - start pulsed while busy → ignored, and the sequence continues unchanged.
